// File: rtl/aes128_sbox_arbiter.sv
// aes128_sbox_arbiter
// -------------------
// Shares one single-port S-box LUT between the key-expansion engine (KX) and
// the sub-bytes engine (SB). At most one byte lookup is granted per cycle,
// round-robin between the two ports. A tag pipeline as deep as the LUT latency
// remembers who issued each lookup, so each result goes back to its requester.
//
// Optional feature (macro AES128_SBOX_ARB_LOCK_EN):
//   KX may hold kx_lock_i high to keep the LUT for a contiguous burst, such as
//   the four bytes of a SubWord. Without the macro kx_lock_i is ignored and
//   arbitration is pure round-robin.
//
// Parameters:
//   SBOX_LAT      cycles from sbox_en_o/sbox_addr_o to a valid sbox_data_i (1..3)
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   flush_i                   synchronous abort: drops in-flight lookups and the lock
//   kx_req_i/kx_byte_i        KX lookup request and byte to substitute
//   kx_lock_i                 KX burst lock hint (lock feature only)
//   kx_gnt_o                  KX request accepted this cycle
//   kx_rsp_valid_o/_data_o    KX result
//   sb_req_i/sb_byte_i        SB lookup request and byte to substitute
//   sb_gnt_o                  SB request accepted this cycle
//   sb_rsp_valid_o/_data_o    SB result
//   sbox_en_o/sbox_addr_o     LUT lookup strobe and address
//   sbox_data_i               LUT result, SBOX_LAT cycles after the strobe
//   busy_o                    at least one lookup in flight
//
// Handshake: the requester raises req with a stable byte and holds both until
// gnt. gnt is combinational from req, the round-robin pointer and the lock
// state. A lookup transfers in a cycle where req and gnt are both high. There
// is no backpressure on the response side: rsp_valid is a single-cycle pulse
// exactly SBOX_LAT cycles after the grant.
module aes128_sbox_arbiter #(
  parameter int SBOX_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       flush_i,
  input  logic       kx_req_i,
  input  logic [7:0] kx_byte_i,
  input  logic       kx_lock_i,
  output logic       kx_gnt_o,
  output logic       kx_rsp_valid_o,
  output logic [7:0] kx_rsp_data_o,
  input  logic       sb_req_i,
  input  logic [7:0] sb_byte_i,
  output logic       sb_gnt_o,
  output logic       sb_rsp_valid_o,
  output logic [7:0] sb_rsp_data_o,
  output logic       sbox_en_o,
  output logic [7:0] sbox_addr_o,
  input  logic [7:0] sbox_data_i,
  output logic       busy_o
);

  // Requester id carried through the tag pipeline: 0 = KX, 1 = SB.
  localparam logic ID_KX = 1'b0;
  localparam logic ID_SB = 1'b1;

  logic                rr_last;   // port that won the most recent grant
  logic                locked;    // KX currently owns the LUT
  logic [SBOX_LAT-1:0] pipe_vld;
  logic [SBOX_LAT-1:0] pipe_id;
  logic                tail_vld;
  logic                tail_id;

`ifdef AES128_SBOX_ARB_LOCK_EN
  typedef enum logic {
    ST_ARB     = 1'b0,
    ST_LOCK_KX = 1'b1
  } lock_state_t;

  lock_state_t lock_state;
  lock_state_t lock_state_nxt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_state <= ST_ARB;
    end else begin
      lock_state <= lock_state_nxt;
    end
  end

  // Every KX grant re-samples the hint, so the last byte of a burst (lock=0)
  // hands the LUT back to round-robin in the same edge that accepts it.
  always_comb begin
    lock_state_nxt = lock_state;
    if (flush_i) begin
      lock_state_nxt = ST_ARB;
    end else if (kx_gnt_o) begin
      lock_state_nxt = kx_lock_i ? ST_LOCK_KX : ST_ARB;
    end
  end

  assign locked = (lock_state == ST_LOCK_KX);
`else
  logic unused_lock;
  assign unused_lock = kx_lock_i;
  assign locked      = 1'b0;
`endif

  // Grants are suppressed while reset is low and in a flush cycle, so a
  // request that coincides with either is simply not accepted.
  always_comb begin
    kx_gnt_o = 1'b0;
    sb_gnt_o = 1'b0;
    if (rst_n_i && !flush_i) begin
      if (locked) begin
        kx_gnt_o = kx_req_i;
      end else if (kx_req_i && sb_req_i) begin
        if (rr_last == ID_SB) begin
          kx_gnt_o = 1'b1;
        end else begin
          sb_gnt_o = 1'b1;
        end
      end else begin
        kx_gnt_o = kx_req_i;
        sb_gnt_o = sb_req_i;
      end
    end
  end

  assign sbox_en_o   = kx_gnt_o | sb_gnt_o;
  assign sbox_addr_o = kx_gnt_o ? kx_byte_i :
                       sb_gnt_o ? sb_byte_i : 8'h00;

  // Reset value SB makes KX win the first tie.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_last <= ID_SB;
    end else if (kx_gnt_o) begin
      rr_last <= ID_KX;
    end else if (sb_gnt_o) begin
      rr_last <= ID_SB;
    end
  end

  // Stage 0 is loaded by the grant; the last stage lines up with the cycle in
  // which the LUT presents the matching result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else if (flush_i) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= sbox_en_o;
      pipe_id[0]  <= sb_gnt_o;
      for (int i = 1; i < SBOX_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  assign tail_vld = pipe_vld[SBOX_LAT-1];
  assign tail_id  = pipe_id[SBOX_LAT-1];

  assign kx_rsp_valid_o = tail_vld && (tail_id == ID_KX);
  assign sb_rsp_valid_o = tail_vld && (tail_id == ID_SB);
  assign kx_rsp_data_o  = kx_rsp_valid_o ? sbox_data_i : 8'h00;
  assign sb_rsp_data_o  = sb_rsp_valid_o ? sbox_data_i : 8'h00;

  assign busy_o = |pipe_vld;

endmodule

// File: tb/tb_aes128_sbox_arbiter.sv
`timescale 1ns/1ps
// Bench for aes128_sbox_arbiter. Two instances (LUT latency 1 and 3) share
// all requester inputs; each has its own LUT model and expected-response
// queue. The driver predicts grants from the round-robin/lock rules and
// pushes the expected S-box result; monitors compare responses and busy.
module tb_aes128_sbox_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef AES128_SBOX_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic       flush_i   = 1'b0;
  logic       kx_req_i  = 1'b0;
  logic [7:0] kx_byte_i = 8'h00;
  logic       kx_lock_i = 1'b0;
  logic       sb_req_i  = 1'b0;
  logic [7:0] sb_byte_i = 8'h00;

  // ---------------- DUT outputs ----------------
  logic       a_kx_gnt, a_kx_vld, a_sb_gnt, a_sb_vld, a_en, a_busy;
  logic [7:0] a_kx_data, a_sb_data, a_addr, a_lut;
  logic       b_kx_gnt, b_kx_vld, b_sb_gnt, b_sb_vld, b_en, b_busy;
  logic [7:0] b_kx_data, b_sb_data, b_addr, b_lut;

  aes128_sbox_arbiter #(.SBOX_LAT(LAT_A)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .kx_req_i(kx_req_i), .kx_byte_i(kx_byte_i), .kx_lock_i(kx_lock_i),
    .kx_gnt_o(a_kx_gnt), .kx_rsp_valid_o(a_kx_vld), .kx_rsp_data_o(a_kx_data),
    .sb_req_i(sb_req_i), .sb_byte_i(sb_byte_i),
    .sb_gnt_o(a_sb_gnt), .sb_rsp_valid_o(a_sb_vld), .sb_rsp_data_o(a_sb_data),
    .sbox_en_o(a_en), .sbox_addr_o(a_addr), .sbox_data_i(a_lut), .busy_o(a_busy)
  );

  aes128_sbox_arbiter #(.SBOX_LAT(LAT_B)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .kx_req_i(kx_req_i), .kx_byte_i(kx_byte_i), .kx_lock_i(kx_lock_i),
    .kx_gnt_o(b_kx_gnt), .kx_rsp_valid_o(b_kx_vld), .kx_rsp_data_o(b_kx_data),
    .sb_req_i(sb_req_i), .sb_byte_i(sb_byte_i),
    .sb_gnt_o(b_sb_gnt), .sb_rsp_valid_o(b_sb_vld), .sb_rsp_data_o(b_sb_data),
    .sbox_en_o(b_en), .sbox_addr_o(b_addr), .sbox_data_i(b_lut), .busy_o(b_busy)
  );

  // ---------------- AES S-box from its definition ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the affine transform.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] r, p, b;
    r = 8'h01; p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // ---------------- LUT models: {en, addr} delayed by the latency ----------------
  logic [8:0]  lut_a = '0;
  logic [26:0] lut_b = '0;
  always @(posedge clk) begin
    lut_a <= {a_en, a_addr};
    lut_b <= {lut_b[17:0], b_en, b_addr};
  end
  assign a_lut = lut_a[8]  ? sbox_f(lut_a[7:0])   : 8'hA5;
  assign b_lut = lut_b[26] ? sbox_f(lut_b[25:18]) : 8'hA5;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;   // cycle in which the response must be visible
    logic        port;  // 0 = KX, 1 = SB
    logic [7:0]  data;
  } exp_t;

  exp_t exp_qa[$];
  exp_t exp_qb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
  endtask

  // ---------------- reference model state ----------------
  logic       m_last_sb = 1'b1;  // previous winner was SB
  logic       m_locked  = 1'b0;
  logic       m_kx, m_sb;
  logic [8:0] kx_todo[$];        // {lock, byte}
  logic [7:0] sb_todo[$];

  // Round-robin: a lone requester wins; on a tie the port that did not win
  // last time wins; a locked KX burst shuts SB out. Nothing in reset/flush.
  task automatic decide();
    m_kx = 1'b0;
    m_sb = 1'b0;
    if (rst_n_i && !flush_i) begin
      if (m_locked)                    m_kx = kx_req_i;
      else if (kx_req_i && sb_req_i)   begin m_kx = m_last_sb; m_sb = !m_last_sb; end
      else                             begin m_kx = kx_req_i; m_sb = sb_req_i; end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic fl);
    logic [8:0]  k;
    logic [10:0] e;
    logic [7:0]  ea;
    if (!kx_req_i && kx_todo.size() > 0) begin
      k = kx_todo.pop_front();
      kx_req_i = 1'b1; kx_lock_i = k[8]; kx_byte_i = k[7:0];
    end
    if (!sb_req_i && sb_todo.size() > 0) begin
      sb_req_i = 1'b1; sb_byte_i = sb_todo.pop_front();
    end
    flush_i = fl;
    @(negedge clk);
    decide();
    ea = m_kx ? kx_byte_i : (m_sb ? sb_byte_i : 8'h00);
    e  = {m_kx, m_sb, m_kx | m_sb, ea};
    check("a_gnt_en_addr", {a_kx_gnt, a_sb_gnt, a_en, a_addr}, e);
    check("b_gnt_en_addr", {b_kx_gnt, b_sb_gnt, b_en, b_addr}, e);
    @(posedge clk);
    #1;
    // cyc now names the cycle after the grant cycle
    if (fl && rst_n_i) begin
      while (exp_qa.size() > 0 && exp_qa[exp_qa.size()-1].due >= cyc) void'(exp_qa.pop_back());
      while (exp_qb.size() > 0 && exp_qb[exp_qb.size()-1].due >= cyc) void'(exp_qb.pop_back());
      m_locked = 1'b0;
    end
    if (m_kx) begin
      exp_qa.push_back('{due: cyc - 1 + LAT_A, port: 1'b0, data: sbox_f(kx_byte_i)});
      exp_qb.push_back('{due: cyc - 1 + LAT_B, port: 1'b0, data: sbox_f(kx_byte_i)});
      m_last_sb = 1'b0;
      m_locked  = LOCK_EN ? kx_lock_i : 1'b0;
      kx_req_i  = 1'b0;
    end
    if (m_sb) begin
      exp_qa.push_back('{due: cyc - 1 + LAT_A, port: 1'b1, data: sbox_f(sb_byte_i)});
      exp_qb.push_back('{due: cyc - 1 + LAT_B, port: 1'b1, data: sbox_f(sb_byte_i)});
      m_last_sb = 1'b1;
      sb_req_i  = 1'b0;
    end
    flush_i = 1'b0;
  endtask

  // Asserts reset asynchronously mid-cycle, checks that every output is 0
  // at once, holds for 'hold' cycles and releases just after a rising edge.
  task automatic async_reset(input int hold);
    #2 rst_n_i = 1'b0;
    #1;
    check("a_reset_outputs", {a_kx_gnt, a_sb_gnt, a_kx_vld, a_sb_vld, a_en, a_busy,
                              a_kx_data, a_sb_data, a_addr}, 32'h0);
    check("b_reset_outputs", {b_kx_gnt, b_sb_gnt, b_kx_vld, b_sb_vld, b_en, b_busy,
                              b_kx_data, b_sb_data, b_addr}, 32'h0);
    exp_qa.delete();
    exp_qb.delete();
    m_last_sb = 1'b1;
    m_locked  = 1'b0;
    @(posedge clk);
    #1;
    repeat (hold) cycle(1'b0);
    rst_n_i = 1'b1;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    exp_t       e;
    logic [8:0] ek, es;
    logic       eb;
    ek = '0; es = '0; eb = 1'b0;
    foreach (exp_qa[i])
      if (exp_qa[i].due >= cyc && exp_qa[i].due <= cyc + LAT_A - 1) eb = 1'b1;
    if (exp_qa.size() > 0 && exp_qa[0].due == cyc) begin
      e = exp_qa.pop_front();
      if (e.port) es = {1'b1, e.data};
      else        ek = {1'b1, e.data};
    end
    check("a_kx_rsp", {a_kx_vld, a_kx_data}, ek);
    check("a_sb_rsp", {a_sb_vld, a_sb_data}, es);
    check("a_busy", a_busy, eb);
  end

  always @(negedge clk) begin : mon_b
    exp_t       e;
    logic [8:0] ek, es;
    logic       eb;
    ek = '0; es = '0; eb = 1'b0;
    foreach (exp_qb[i])
      if (exp_qb[i].due >= cyc && exp_qb[i].due <= cyc + LAT_B - 1) eb = 1'b1;
    if (exp_qb.size() > 0 && exp_qb[0].due == cyc) begin
      e = exp_qb.pop_front();
      if (e.port) es = {1'b1, e.data};
      else        ek = {1'b1, e.data};
    end
    check("b_kx_rsp", {b_kx_vld, b_kx_data}, ek);
    check("b_sb_rsp", {b_sb_vld, b_sb_data}, es);
    check("b_busy", b_busy, eb);
  end

  // ---------------- test sequence ----------------
  initial begin
    @(posedge clk);
    #1;
    check("a_reset_outputs", {a_kx_gnt, a_sb_gnt, a_kx_vld, a_sb_vld, a_en, a_busy,
                              a_kx_data, a_sb_data, a_addr}, 32'h0);
    repeat (2) cycle(1'b0);
    rst_n_i = 1'b1;

    // Lone KX lookup of 0x53 -> 0xED
    kx_todo.push_back({1'b0, 8'h53});
    repeat (5) cycle(1'b0);

    // Fresh tie from reset: KX,SB,KX,SB -> 0x63,0x16,0x7C,0xED
    async_reset(2);
    kx_todo.push_back({1'b0, 8'h00});
    kx_todo.push_back({1'b0, 8'h01});
    sb_todo.push_back(8'hFF);
    sb_todo.push_back(8'h53);
    repeat (8) cycle(1'b0);

    // SB back-to-back burst of four
    sb_todo.push_back(8'h10);
    sb_todo.push_back(8'h20);
    sb_todo.push_back(8'h30);
    sb_todo.push_back(8'h40);
    repeat (9) cycle(1'b0);

    // Two lookups in flight, then a one-cycle flush with a request pending
    kx_todo.push_back({1'b0, 8'hAA});
    sb_todo.push_back(8'hBB);
    repeat (2) cycle(1'b0);
    kx_todo.push_back({1'b0, 8'hCC});
    cycle(1'b1);
    repeat (6) cycle(1'b0);

    // Reset in the middle of a mixed burst, then a tie after release
    for (int i = 0; i < 4; i++) begin
      sb_todo.push_back(8'($urandom_range(0, 255)));
      kx_todo.push_back({1'b0, 8'($urandom_range(0, 255))});
    end
    repeat (3) cycle(1'b0);
    async_reset(2);
    repeat (12) cycle(1'b0);

    // SubWord burst: KX lock 1,1,1,0 against a continuously requesting SB
    for (int i = 0; i < 4; i++) begin
      kx_todo.push_back({(i != 3), 8'(8'h20 + i)});
      sb_todo.push_back(8'(8'h90 + i));
    end
    repeat (12) cycle(1'b0);

    // Randomized traffic with occasional flushes and one mid-run reset
    for (int n = 0; n < 1500; n++) begin
      if (kx_todo.size() < 3 && $urandom_range(0, 2) == 0)
        kx_todo.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
      if (sb_todo.size() < 3 && $urandom_range(0, 2) != 0)
        sb_todo.push_back(8'($urandom_range(0, 255)));
      if (n == 700) async_reset(2);
      else cycle($urandom_range(0, 39) == 0);
    end

    // Drain
    kx_todo.delete();
    sb_todo.delete();
    repeat (40) cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
